regfile_arb: RTL
================

REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameter: DW, default 16, width of every data word.
REQ-002 Parameter: NREG, default 4, number of bank registers; address width is clog2(NREG), which is 2 at the default.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: reqA  input  1  requester A write request; level signal, held until gntA.
REQ-006 Port: addrA  input  2  requester A target register; stable while reqA is high.
REQ-007 Port: dataA  input  DW  requester A write data; stable while reqA is high.
REQ-008 Port: gntA  output  1  one-cycle pulse; A's write is committed.
REQ-009 Port: reqB, addrB, dataB, gntB  same as REQ-005..REQ-008, for requester B.
REQ-010 Port: rd_addr  input  2  read-port register select.
REQ-011 Port: rd_data  output  DW  combinational read of bank[rd_addr].
REQ-012 Port: busy  output  1  high while the FSM is in WRITE.

Function
REQ-013 FSM shall have two states, IDLE and WRITE.
REQ-014 IDLE with no request: remain in IDLE; no bank enable asserted.
REQ-015 IDLE with reqA or reqB high: select a winner, latch its addr and data into holding registers, record the winner, and go to WRITE on the next edge.
REQ-016 Single requester: that requester wins regardless of the priority pointer.
REQ-017 Both requesters high: the requester named by the priority pointer wins.
REQ-018 Priority pointer reset value is A.
REQ-019 Priority pointer update: after each completed write, the pointer points to the requester that did not win.
REQ-020 WRITE: assert exactly one bank enable, en[held_addr], for that single cycle; the bank captures held_data at the edge ending WRITE.
REQ-021 WRITE: pulse the winner's gnt high for that cycle only; the loser's gnt stays low.
REQ-022 WRITE: return to IDLE unconditionally on the next edge.
REQ-023 Throughput: at most one write per 2 cycles.
REQ-024 Latency: 2 edges from req high in IDLE to data visible on rd_data.
REQ-025 Requester obligation: a requester drops req in the cycle after its gnt.
REQ-026 Requests arriving during WRITE are not sampled; they are evaluated in the next IDLE.
REQ-027 A losing requester's req stays pending and is served next without re-request.
REQ-028 Hold invariance: addr/data changes during WRITE do not affect the committed write, because the holding registers are used.
REQ-029 rd_data shows the old value during WRITE and the new value from the following cycle.
REQ-030 Reading the address being written is not forwarded.
REQ-031 gntA and gntB are never high together; at most one bank enable is high in any cycle.

Reset
REQ-032 Assertion of rst_n low immediately forces: state=IDLE, pointer=A, holding registers=0, all bank registers=0, gntA=gntB=0, busy=0, all enables low.
REQ-033 Reset asserted during WRITE aborts the write; the target register reads 0 after reset and no gnt is issued.
REQ-034 First request is sampled on the first rising edge after rst_n deasserts.

Structure
REQ-035 Package regfile_arb_pkg holds: the state enum (IDLE, WRITE), requester id enum (REQ_A, REQ_B), and the DW and NREG defaults.
REQ-036 One sub-module, regbank: NREG x DW enable registers, each with async active-low clear on rst_n, one-hot en input, and combinational read mux.
REQ-037 FSM, priority pointer and holding registers reside in regfile_arb.

Verification
REQ-038 Scenario: reset, then reqA=1, addrA=2, dataA=16'hBEEF -> gntA pulses in cycle 2, busy=1 in cycle 2, rd_addr=2 reads BEEF from cycle 3.
REQ-039 Scenario: after reset, reqA and reqB both high same cycle (A: addr 0, 16'h1111; B: addr 1, 16'h2222) -> A granted first, B granted 2 cycles later; no overlapping gnts.
REQ-040 Scenario: A and B both request continuously to addr 3 -> grants alternate A,B,A,B; final bank[3] equals the last grantee's data.
REQ-041 Scenario: change dataA from 16'h00FF to 16'hFF00 during WRITE -> bank holds 16'h00FF.
REQ-042 Scenario: pull rst_n low during WRITE of 16'hCAFE to addr 1 -> no gnt, bank[1]=0, state IDLE.
REQ-043 Scenario: hold rd_addr=2 during a write of 16'h1234 to addr 2 -> rd_data shows the old value during WRITE and 1234 from the next cycle.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the two-requester register-file arbiter.
package regfile_arb_pkg;

  localparam int unsigned DW_DEFAULT   = 16;
  localparam int unsigned NREG_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/regbank.sv
// NREG x DW register bank: one-hot write enables, async clear, combinational read.
module regbank #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREG-1:0] en,
  input  logic [DW-1:0]   wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  // Next-state: each enabled register takes the write data.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
      if (en[i]) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Bank storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read is not forwarded: a register being written shows its old value.
  always_comb begin
    rd_data = mem_q[rd_addr];
  end

endmodule

// File: rtl/regfile_arb.sv
// Two-requester write arbiter in front of a register bank. A request is
// latched in IDLE, committed during a single WRITE cycle, then the priority
// pointer moves to the requester that lost.
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DW   = DW_DEFAULT,
  parameter int unsigned NREG = NREG_DEFAULT,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reqA,
  input  logic [AW-1:0] addrA,
  input  logic [DW-1:0] dataA,
  output logic          gntA,
  input  logic          reqB,
  input  logic [AW-1:0] addrB,
  input  logic [DW-1:0] dataB,
  output logic          gntB,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy
);

  state_e        state_q, state_d;
  req_id_e       ptr_q, ptr_d;
  req_id_e       win_q, win_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [NREG-1:0] en;

  // Arbitration and next-state: sample requests only in IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (reqA || reqB) begin
          // A wins when alone, or when both request and the pointer names A.
          if (reqA && (!reqB || (ptr_q == REQ_A))) begin
            win_d  = REQ_A;
            addr_d = addrA;
            data_d = dataA;
          end else begin
            win_d  = REQ_B;
            addr_d = addrB;
            data_d = dataB;
          end
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        ptr_d   = (win_q == REQ_A) ? REQ_B : REQ_A;
      end
    endcase
  end

  // FSM, pointer and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= REQ_A;
      win_q   <= REQ_A;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Outputs: grant and enable are driven only while in WRITE.
  always_comb begin
    busy = (state_q == WRITE);
    gntA = busy && (win_q == REQ_A);
    gntB = busy && (win_q == REQ_B);
    en   = '0;
    if (busy) begin
      en[addr_q] = 1'b1;
    end
  end

  regbank #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_data (data_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
